// File: rtl/state_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : state_monitor
//  Description : Receiving-end checker for a free-running state sequencer.
//                Locks onto the sequence, flags broken steps, counts errors
//                (saturating), pulses on wrap and one-hot decodes the state.
//  Revision    : 1.0 - initial release
// ============================================================================
module state_monitor #(
    parameter int STATE_W   = 4,
    parameter int STATE_NUM = 16,
    parameter int LOCK_CNT  = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic [STATE_W-1:0]   i_state,
    output logic                 o_locked,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output logic                 o_wrap,
    output logic [STATE_NUM-1:0] o_dec
);

    localparam int                 c_GC_W   = $clog2(LOCK_CNT + 1);
    localparam logic [c_GC_W-1:0]  c_LOCK   = c_GC_W'(LOCK_CNT);
    localparam logic [STATE_W:0]   c_NUM    = (STATE_W + 1)'(STATE_NUM);
    localparam logic [STATE_W-1:0] c_LAST   = STATE_W'(STATE_NUM - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SYNC   = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    logic [1:0]           fsm_q, fsm_d;
    logic [STATE_W-1:0]   prev_state_q;
    logic                 prev_en_q;
    logic [c_GC_W-1:0]    good_cnt_q, good_cnt_d;
    logic                 err_q, err_d;
    logic                 wrap_q, wrap_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [STATE_NUM-1:0] dec_q, dec_d;

    logic [STATE_W-1:0]   w_expected;
    logic                 w_in_range;
    logic                 w_good;
    logic                 w_wrap_step;

    // Expected sample: advance (with wrap at the last legal state) when the
    // previous sample was enabled, otherwise the sequencer holds.
    always_comb begin
        w_expected = prev_state_q;
        if (prev_en_q) begin
            w_expected = (prev_state_q == c_LAST) ? '0 : prev_state_q + 1'b1;
        end
        w_in_range  = ({1'b0, i_state} < c_NUM);
        w_good      = w_in_range && (i_state == w_expected);
        w_wrap_step = prev_en_q && (prev_state_q == c_LAST) && (i_state == '0);
    end

    // One-hot decode; out-of-range values match no bit and decode to zero.
    always_comb begin
        dec_d = '0;
        for (int k = 0; k < STATE_NUM; k++) begin
            dec_d[k] = (i_state == STATE_W'(k));
        end
    end

    // Lock FSM next-state, error/wrap pulses and saturating error count.
    always_comb begin
        fsm_d      = fsm_q;
        good_cnt_d = good_cnt_q;
        err_d      = 1'b0;
        wrap_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        case (fsm_q)
            c_IDLE: begin
                if (i_en) begin
                    fsm_d      = c_SYNC;
                    good_cnt_d = '0;
                end
            end
            c_SYNC: begin
                if (w_good) begin
                    if (prev_en_q) begin
                        if ((good_cnt_q + 1'b1) == c_LOCK) begin
                            fsm_d      = c_LOCKED;
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    good_cnt_d = '0;
                end
            end
            c_LOCKED: begin
                if (!w_good) begin
                    err_d      = 1'b1;
                    fsm_d      = c_SYNC;
                    good_cnt_d = '0;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end else if (w_wrap_step) begin
                    wrap_d = 1'b1;
                end
            end
            default: begin
                fsm_d      = c_IDLE;
                good_cnt_d = '0;
            end
        endcase
    end

    // State and output registers; the previous sample is recaptured every edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q        <= c_IDLE;
            prev_state_q <= '0;
            prev_en_q    <= 1'b0;
            good_cnt_q   <= '0;
            err_q        <= 1'b0;
            wrap_q       <= 1'b0;
            err_cnt_q    <= '0;
            dec_q        <= '0;
        end else begin
            fsm_q        <= fsm_d;
            prev_state_q <= i_state;
            prev_en_q    <= i_en;
            good_cnt_q   <= good_cnt_d;
            err_q        <= err_d;
            wrap_q       <= wrap_d;
            err_cnt_q    <= err_cnt_d;
            dec_q        <= dec_d;
        end
    end

    assign o_locked  = (fsm_q == c_LOCKED);
    assign o_err     = err_q;
    assign o_wrap    = wrap_q;
    assign o_err_cnt = err_cnt_q;
    assign o_dec     = dec_q;

endmodule
`default_nettype wire

// File: tb/tb_state_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_state_monitor
//  Description : Scoreboard bench for state_monitor (12 states, 2-bit error
//                counter). A reference model predicts each sample's outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_state_monitor;

    localparam int SW = 4;
    localparam int SN = 12;
    localparam int LC = 3;
    localparam int EW = 2;

    typedef struct packed {
        logic          locked;
        logic          err;
        logic          wrap;
        logic [EW-1:0] cnt;
        logic [SN-1:0] dec;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [SW-1:0] st;
    logic          o_locked;
    logic          o_err;
    logic [EW-1:0] o_err_cnt;
    logic          o_wrap;
    logic [SN-1:0] o_dec;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t e;

    // Reference model state: mode 0 = idle, 1 = syncing, 2 = locked
    int m_mode, m_prev, m_prev_en, m_good, m_errs;

    state_monitor #(
        .STATE_W  (SW),
        .STATE_NUM(SN),
        .LOCK_CNT (LC),
        .ERR_CNT_W(EW)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_state  (st),
        .o_locked (o_locked),
        .o_err    (o_err),
        .o_err_cnt(o_err_cnt),
        .o_wrap   (o_wrap),
        .o_dec    (o_dec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_prev_en = 0; m_good = 0; m_errs = 0;
    endtask

    // Predict the outputs produced by the edge that samples (a_en, a_st).
    task automatic issue(input int a_en, input int a_st);
        exp_t x;
        int   want;
        bit   good;
        en   = a_en[0];
        st   = SW'(a_st);
        want = m_prev;
        if (m_prev_en != 0) want = (m_prev == SN - 1) ? 0 : (m_prev + 1) % (1 << SW);
        good = (a_st < SN) && (a_st == want);
        x = '0;
        if (m_mode == 0) begin
            if (a_en != 0) begin m_mode = 1; m_good = 0; end
        end else if (m_mode == 1) begin
            if (!good) m_good = 0;
            else if (m_prev_en != 0) begin
                m_good++;
                if (m_good >= LC) begin m_mode = 2; m_good = 0; end
            end
        end else begin
            if (!good) begin
                x.err = 1'b1; m_errs++; m_mode = 1; m_good = 0;
            end else if (m_prev_en != 0 && m_prev == SN - 1 && a_st == 0) begin
                x.wrap = 1'b1;
            end
        end
        x.locked = (m_mode == 2);
        x.cnt    = EW'((m_errs > (1 << EW) - 1) ? (1 << EW) - 1 : m_errs);
        x.dec    = (a_st < SN) ? SN'(1) << a_st : '0;
        m_prev    = a_st;
        m_prev_en = a_en;
        sb_q.push_back(x);
    endtask

    task automatic step(input int a_en, input int a_st);
        @(negedge clk);
        issue(a_en, a_st);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_locked"}, int'(o_locked), 0);
        chk({tag, "_err"},    int'(o_err), 0);
        chk({tag, "_wrap"},   int'(o_wrap), 0);
        chk({tag, "_cnt"},    int'(o_err_cnt), 0);
        chk({tag, "_dec"},    int'(o_dec), 0);
    endtask

    // Reset asserted between edges: outputs must clear without a clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        en    = 1'b0;
        model_reset();
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, int'(st));
    endtask

    // Monitor: every predicted sample is compared just after its edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("locked",  int'(o_locked),  int'(e.locked));
            chk("err",     int'(o_err),     int'(e.err));
            chk("wrap",    int'(o_wrap),    int'(e.wrap));
            chk("err_cnt", int'(o_err_cnt), int'(e.cnt));
            chk("dec",     int'(o_dec),     int'(e.dec));
        end
    end

    initial begin
        int sq;
        int r;
        int ren;
        int rst;
        rst_n = 1'b0;
        en    = 1'b0;
        st    = '0;
        model_reset();
        #100;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 0);
        repeat (3) step(0, 0);

        // lock on 0..3, then run through the wrap 11 -> 0
        for (int i = 0; i < 14; i++) step(1, i % SN);
        // hold at 5 with enable low, then a step while held is an error
        step(1, 2); step(1, 3); step(1, 4);
        repeat (4) step(0, 5);
        step(1, 6);
        // relock, skip 3 -> 5, relock on 6,7,8, then an out-of-range value
        for (int i = 7; i < 12; i++) step(1, i);
        for (int i = 0; i < 4; i++) step(1, i);
        step(1, 5);
        step(1, 6); step(1, 7); step(1, 8);
        step(1, 15);
        // saturation: five violations each after relocking
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 4; i++) step(1, b + i);
            step(1, (b + 6) % SN);
        end
        // reset mid-lock
        for (int i = 0; i < 5; i++) step(1, i);
        async_reset();

        // randomized sequencer with occasional glitches and resets
        sq = 0;
        for (int n = 0; n < 800; n++) begin
            r   = int'($urandom_range(0, 99));
            ren = ($urandom_range(0, 3) != 0) ? 1 : 0;
            if (r == 99) begin
                async_reset();
            end else begin
                rst = (r < 4) ? int'($urandom_range(0, 15)) : sq;
                step(ren, rst);
                if (ren != 0) sq = (rst >= SN - 1) ? 0 : rst + 1;
                else          sq = rst % SN;
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/state_monitor.md
Name: state_monitor

Overview:
Receiving-end checker for the 4-bit free-running state sequencer. It samples the sequencer's enable and state bus each cycle, locks onto the sequence and flags any step that breaks it. It also reports a one-hot decode of the current state, a wrap pulse and a saturating error count. It sits beside the sequencer as its consumer and self-check.

Parameters:
STATE_W, 4, width of i_state
STATE_NUM, 16, number of legal states (0..STATE_NUM-1); must be <= 2**STATE_W
LOCK_CNT, 3, consecutive good enabled steps required to declare lock (>=1)
ERR_CNT_W, 8, width of the saturating error counter

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  sequencer enable, same cycle as the state it accompanies
i_state  input  STATE_W  sequencer state bus
o_locked  output  1  high while FSM is LOCKED
o_err  output  1  one-cycle pulse on a sequence violation while LOCKED
o_err_cnt  output  ERR_CNT_W  saturating count of o_err pulses
o_wrap  output  1  one-cycle pulse on a good STATE_NUM-1 -> 0 step while LOCKED
o_dec  output  STATE_NUM  one-hot decode of sampled i_state

Behaviour:
- Reset is asynchronous and active-low. The clock is i_clk, the reset is i_rst_n.
- On reset, all outputs are 0, FSM = IDLE, and internal prev_state/prev_en/good_cnt are 0. Reset mid-operation clears everything immediately, with no clock required.
- All outputs are registered. Each is updated on the rising edge that samples the input and is visible after that edge, so latency is 1 cycle.
- Expected value for the current sample:
  - If prev_en = 1: expected = prev_state + 1, wrapping STATE_NUM-1 -> 0.
  - If prev_en = 0: expected = prev_state (hold).
- Good step: i_state == expected and i_state < STATE_NUM. Any out-of-range i_state is always bad.
- Every edge: prev_state <= i_state and prev_en <= i_en.
- o_dec <= bit i_state set if i_state < STATE_NUM, else all 0. This updates in every FSM state.
- IDLE:
  - If i_en = 1: capture the sample and go to SYNC with good_cnt = 0.
  - Otherwise stay in IDLE; nothing is checked.
- SYNC:
  - Good step with prev_en = 1: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED.
  - Good step with prev_en = 0 (hold): good_cnt is unchanged.
  - Bad step: good_cnt = 0, recapture the current sample, stay in SYNC. No o_err and no count.
- LOCKED:
  - Good step: stay in LOCKED.
  - Good step from STATE_NUM-1 to 0 with prev_en = 1: o_wrap = 1 for one cycle.
  - Bad step: o_err = 1 for one cycle, o_err_cnt++ (holds at all-ones), go to SYNC with good_cnt = 0, recapture the current sample.
- o_locked = (FSM == LOCKED). It is the registered state, so it rises on the edge that completes the LOCK_CNT-th good step.
- Simultaneous events: a bad step takes priority over wrap, so o_wrap = 0 whenever o_err = 1.
- o_err_cnt is cleared only by reset.

Test Plan:
1. Reset: hold i_rst_n low 100 ns with the clock running -> o_locked=0, o_err=0, o_wrap=0, o_err_cnt=0, o_dec=0. Deassert reset, keep i_en=0 -> FSM stays IDLE, o_locked=0.
2. Lock: i_en=1, i_state 0,1,2,3 on successive edges -> o_locked=1 after the edge sampling 3; o_dec=16'h0008 at that point; o_err never asserts.
3. Wrap: locked, feed 14,15,0,1 with i_en=1 -> o_wrap=1 for exactly the cycle after 0 is sampled; o_locked stays 1; o_err_cnt unchanged.
4. Hold: locked at 5, drop i_en for 4 cycles with i_state=5 -> no error, o_locked=1. Then i_state=6 while the prior i_en=0 -> o_err pulse, o_err_cnt=1, o_locked=0.
5. Skip and relock: locked, feed 3 then 5 -> o_err pulse and o_err_cnt increments. Feed 6,7,8 -> o_locked=1 again after the edge sampling 8. i_state=4'hF with STATE_NUM=12 -> o_dec=0 and o_err pulse.
6. Saturation and reset: ERR_CNT_W=2, inject 5 violations each followed by relock -> o_err_cnt stays at 3 after the 3rd. Assert i_rst_n mid-lock between edges -> all outputs 0 immediately.
